ram_queue_fifo: RTL

Parametrised circular FIFO built on a registered-read dual-port RAM, replacing the bare 8-bit/384-entry RAM with a self-managing queue. It adds write/read pointers with wrap at a non-power-of-two depth, occupancy count, full/empty flags, sticky error flags and a synchronous flush. It sits between a sample producer (capture/ADC side) and a slower consumer (display/UART side).

---
 rtl/ram_queue_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_queue_fifo.sv
// Circular FIFO over a registered-read RAM with a non-power-of-two depth, occupancy count and sticky error flags.
// Define RAMQUEUE_OVERWRITE_EN to make a write into a full queue overwrite the oldest word.
module ram_queue_fifo #(
  parameter int DATA_W  = 8,
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

`ifdef RAMQUEUE_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(ENTRIES - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(ENTRIES);

  logic [DATA_W-1:0] mem_r [ENTRIES];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r, count_nxt_s;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r, empty_r, full_r, overflow_r, underflow_r;
  logic              rd_acc_s, wr_acc_s, ovf_evt_s, udf_evt_s, ovw_s, wr_do_s, rd_adv_s;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {ADDR_W{1'b0}};
    end else begin
      ptr_inc = p + ADDR_W'(1);
    end
  endfunction

  // Accept decisions and next occupancy
  always_comb begin
    rd_acc_s    = rd_en && !empty_r;
    wr_acc_s    = wr_en && (!full_r || rd_acc_s);
    ovf_evt_s   = wr_en && full_r && !rd_acc_s;
    udf_evt_s   = rd_en && empty_r;
    // In capture mode a full-write evicts the oldest word instead of being dropped
    ovw_s       = OVERWRITE && ovf_evt_s;
    wr_do_s     = wr_acc_s || ovw_s;
    rd_adv_s    = rd_acc_s || ovw_s;
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + (ADDR_W + 1)'(1);
      2'b01:   count_nxt_s = count_r - (ADDR_W + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_do_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, flags and registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W + 1){1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W + 1){1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      if (wr_do_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_adv_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      // Read-before-write: when full, rd_ptr == wr_ptr and the old word is returned
      if (rd_acc_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
      count_r     <= count_nxt_s;
      empty_r     <= (count_nxt_s == {(ADDR_W + 1){1'b0}});
      full_r      <= (count_nxt_s == FULL_CNT);
      overflow_r  <= overflow_r | ovf_evt_s;
      underflow_r <= underflow_r | udf_evt_s;
      rd_valid_r  <= rd_acc_s;
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule
